// File: rtl/reg_file_bp_pkg.sv
// rv_regfile_pkg: shared constants and types for the integer register file.
//   XLEN_DEF / NREGS_DEF   default register width and register count
//   SP_INIT_DEF / GP_INIT_DEF reset values of x2 (sp) and x3 (gp)
//   reg_addr_t             register address type for the default NREGS
//   X0_ADDR                address of the hard-wired zero register
package rv_regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;
  localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t X0_ADDR = reg_addr_t'(0);

endpackage

// File: rtl/reg_file_bp_if.sv
// reg_file_bp_if: decode/writeback bus of the register file.
//   master  : pipeline side (drives read addresses, alloc, writeback, flush)
//   slave   : register file side (drives read data, ready bits, busy vector)
// Signals:
//   rd_addr  NUM_RD*AW    packed read addresses, port p at [p*AW +: AW]
//   rd_data  NUM_RD*XLEN  packed read data (combinational)
//   rd_ready NUM_RD       port p register has no outstanding write
//   alloc_en/alloc_addr   destination allocation from decode
//   wb_en/wb_addr/wb_data register update from writeback
//   flush                 clears all pending bits
//   busy_vec NREGS        registered pending vector
interface reg_file_bp_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_ready;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   flush;
  logic [NREGS-1:0]       busy_vec;

  modport master (
    output rd_addr, alloc_en, alloc_addr, wb_en, wb_addr, wb_data, flush,
    input  rd_data, rd_ready, busy_vec
  );

  modport slave (
    input  rd_addr, alloc_en, alloc_addr, wb_en, wb_addr, wb_data, flush,
    output rd_data, rd_ready, busy_vec
  );

endinterface

// File: rtl/reg_file_bp_scoreboard.sv
// reg_scoreboard: pending-write tracker for the register file.
//   clock, rst            clock and synchronous active-high reset
//   alloc_en/alloc_addr   marks a destination register pending
//   wb_en/wb_addr         clears the pending bit of the written register
//   flush                 clears every pending bit
//   rd_addr               packed read addresses for the ready lookup
//   busy_vec              registered pending vector
//   rd_ready              per-port "operand safe to consume"
module reg_scoreboard
  import rv_regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 alloc_en_i,
  input  logic [AW-1:0]        alloc_addr_i,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic                 flush_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NREGS-1:0]     busy_vec_o,
  output logic [NUM_RD-1:0]    rd_ready_o
);

  localparam logic [AW-1:0] ZERO_A = AW'(X0_ADDR);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next pending vector: flush beats alloc, alloc beats writeback (the
  // allocating instruction is the younger producer).
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_en_i) begin
        busy_d[wb_addr_i] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (alloc_en_i && (alloc_addr_i != ZERO_A)) begin
        busy_d[alloc_addr_i] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clock) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  // A same-cycle writeback makes the operand available through the bypass.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_ready
    logic [AW-1:0] ra_s;
    assign ra_s = rd_addr_i[p*AW +: AW];
    assign rd_ready_o[p] = (ra_s == ZERO_A) || !busy_q[ra_s] ||
                           (wb_en_i && (wb_addr_i == ra_s));
  end

endmodule

// File: rtl/reg_file_bp.sv
// reg_file_bp: integer register file with NUM_RD read ports, write-to-read
// bypass and a pending-write scoreboard.
//   clock, rst   clock and synchronous active-high reset
//   bus (slave)  decode/writeback bus, see reg_file_bp_if
module reg_file_bp
  import rv_regfile_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned NUM_RD  = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
  parameter logic [XLEN-1:0] GP_INIT = XLEN'(GP_INIT_DEF),
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic        clock,
  input  logic        rst,
  reg_file_bp_if.slave bus
);

  localparam logic [AW-1:0] ZERO_A = AW'(X0_ADDR);

  logic [XLEN-1:0] mem_q [NREGS];

  // Register array: reset image (sp/gp preset) and writeback port; x0 is
  // never written so it stays zero.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == 2) begin
          mem_q[i] <= SP_INIT;
        end else if (i == 3) begin
          mem_q[i] <= GP_INIT;
        end else begin
          mem_q[i] <= '0;
        end
      end
    end else if (bus.wb_en && (bus.wb_addr != ZERO_A)) begin
      mem_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read muxes: a writeback to the same non-zero register is forwarded.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] ra_s;
    assign ra_s = bus.rd_addr[p*AW +: AW];
    assign bus.rd_data[p*XLEN +: XLEN] =
        (ra_s == ZERO_A)                       ? '0 :
        (bus.wb_en && (bus.wb_addr == ra_s))   ? bus.wb_data :
                                                 mem_q[ra_s];
  end

  reg_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clock        (clock),
    .rst          (rst),
    .alloc_en_i   (bus.alloc_en),
    .alloc_addr_i (bus.alloc_addr),
    .wb_en_i      (bus.wb_en),
    .wb_addr_i    (bus.wb_addr),
    .flush_i      (bus.flush),
    .rd_addr_i    (bus.rd_addr),
    .busy_vec_o   (bus.busy_vec),
    .rd_ready_o   (bus.rd_ready)
  );

endmodule
